// File: rtl/opc_sevenseg_pkg.sv
// Shared constants for the OPC seven-segment scanner: glyph table and tick divider.
package opc_sevenseg_pkg;

  // Hex glyphs, active-high, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] HEX7 [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  // Clocks per phase tick; each digit slot is 16 ticks long
  function automatic int f_tick_div(input int clkspeed, input int refresh_hz);
    return clkspeed / (refresh_hz * 16);
  endfunction

endpackage

// File: rtl/opc_hex7seg.sv
// Combinational nibble to active-high seven-segment glyph.
module opc_hex7seg
  import opc_sevenseg_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] glyph
);

  assign glyph = HEX7[nib];

endmodule

// File: rtl/opc_sevenseg_scan.sv
// N-digit multiplexed seven-segment scanner with PWM brightness,
// double-buffered frame-aligned updates and leading-zero suppression.
module opc_sevenseg_scan
  import opc_sevenseg_pkg::*;
#(
  parameter int CLKSPEED    = 40000000,
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_HZ  = 1000,
  parameter bit SEG_ACT_LOW = 1'b1,
  parameter bit AN_ACT_LOW  = 1'b1
) (
  input  logic                    clk,
  input  logic                    reset_b,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    load,
  input  logic                    lzs,
  input  logic [3:0]              duty,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_sync
);

  localparam int TICK_DIV = f_tick_div(CLKSPEED, REFRESH_HZ);
  localparam int PRE_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int IDX_W    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [PRE_W-1:0]      TICK_LAST = PRE_W'(TICK_DIV - 1);
  localparam logic [IDX_W-1:0]      IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
  localparam logic [6:0]            SEG_OFF   = SEG_ACT_LOW ? 7'h7F : 7'h00;
  localparam logic [NUM_DIGITS-1:0] AN_OFF    = AN_ACT_LOW ? '1 : '0;

  if (TICK_DIV < 1 || NUM_DIGITS < 1 || NUM_DIGITS > 8) begin : g_bad_param
    $error("opc_sevenseg_scan: TICK_DIV must be >= 1 and NUM_DIGITS in 1..8");
  end

  logic [PRE_W-1:0] pre;
  logic [3:0]       phase;
  logic [IDX_W-1:0] idx;
  logic [3:0]       duty_q;
  logic             tick, slot_end, wrap;

  logic [NUM_DIGITS-1:0][3:0] shd_val, act_val;
  logic [NUM_DIGITS-1:0]      shd_dp, act_dp;
  logic                       pending;

  logic [NUM_DIGITS-1:0] blank, an_on;
  logic [6:0]            glyph;

  assign tick     = (pre == TICK_LAST);
  assign slot_end = tick && (phase == 4'hF);
  assign wrap     = slot_end && (idx == IDX_LAST);

  // Prescaler, phase and digit index; brightness latched only between slots
  always_ff @(posedge clk) begin
    if (!reset_b) begin
      pre    <= '0;
      phase  <= '0;
      idx    <= '0;
      duty_q <= '0;
    end else begin
      pre <= tick ? '0 : pre + 1'b1;
      if (tick) phase <= phase + 1'b1;
      if (slot_end) begin
        duty_q <= duty;
        idx    <= wrap ? '0 : idx + 1'b1;
      end
    end
  end

  // Shadow/active buffers: the active copy only ever changes at frame wrap
  always_ff @(posedge clk) begin
    if (!reset_b) begin
      shd_val <= '0;
      shd_dp  <= '0;
      act_val <= '0;
      act_dp  <= '0;
      pending <= 1'b0;
    end else if (wrap) begin
      pending <= 1'b0;
      if (load) begin
        act_val <= value;
        act_dp  <= dp_in;
      end else if (pending) begin
        act_val <= shd_val;
        act_dp  <= shd_dp;
      end
    end else if (load) begin
      shd_val <= value;
      shd_dp  <= dp_in;
      pending <= 1'b1;
    end
  end

  // Leading-zero mask: running AND of "nibble and dp clear" from the top digit down
  always_comb begin
    logic zr;
    blank = '0;
    zr    = lzs;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      zr       = zr && (act_val[i] == 4'h0) && !act_dp[i];
      blank[i] = zr;
    end
  end

  // Anode enable for the selected digit; phase 15 never passes since duty_q <= 15
  always_comb begin
    an_on = '0;
    if (phase < duty_q) an_on[idx] = 1'b1;
  end

  opc_hex7seg u_hex7 (
    .nib   (act_val[idx]),
    .glyph (glyph)
  );

  // Output registers with pin polarity applied; reset forces everything dark
  always_ff @(posedge clk) begin
    if (!reset_b) begin
      seg        <= SEG_OFF;
      dp         <= SEG_ACT_LOW;
      an         <= AN_OFF;
      frame_sync <= 1'b0;
    end else begin
      seg        <= (blank[idx] ? 7'h00 : glyph) ^ SEG_OFF;
      dp         <= (act_dp[idx] & ~blank[idx]) ^ SEG_ACT_LOW;
      an         <= an_on ^ AN_OFF;
      frame_sync <= wrap;
    end
  end

endmodule

// File: tb/tb_opc_sevenseg_scan.sv
// Scoreboard bench: a frame-level reference model predicts every output cycle,
// a monitor on the falling edge pops and compares.
module tb_opc_sevenseg_scan;

  localparam int N = 4;

  logic          clk = 1'b0;
  logic          reset_b = 1'b0;
  logic [15:0]   value = 16'h0;
  logic [3:0]    dp_in = 4'h0;
  logic          load = 1'b0;
  logic          lzs = 1'b0;
  logic [3:0]    duty = 4'h0;
  logic [6:0]    seg;
  logic          dp;
  logic [3:0]    an;
  logic          frame_sync;

  always #5 clk = ~clk;

  opc_sevenseg_scan #(
    .CLKSPEED(1600), .NUM_DIGITS(N), .REFRESH_HZ(25),
    .SEG_ACT_LOW(1'b1), .AN_ACT_LOW(1'b1)
  ) dut (
    .clk(clk), .reset_b(reset_b), .value(value), .dp_in(dp_in), .load(load),
    .lzs(lzs), .duty(duty), .seg(seg), .dp(dp), .an(an), .frame_sync(frame_sync)
  );

  typedef struct packed {
    logic [6:0] seg;
    logic       dp;
    logic [3:0] an;
    logic       fs;
  } exp_t;

  exp_t q[$];
  exp_t m_e;
  int   n_cmp = 0;
  int   n_bad = 0;

  logic [6:0] glyph [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  // Reference model: t counts run cycles since reset; 4 clk/tick, 64 clk/slot,
  // 256 clk/frame. Display content of a frame is the latest load at or before
  // the edge that starts it. Output after an edge reflects the state before it.
  int          t = 0;
  int          dq = 0;
  logic [15:0] lat_v = 0, shw_v = 0;
  logic [3:0]  lat_d = 0, shw_d = 0;

  always @(posedge clk) begin
    exp_t e;
    int ph, ix;
    bit bl, wrp;
    logic [3:0] nib;
    if (!reset_b) begin
      e = '{seg: 7'h7F, dp: 1'b1, an: 4'hF, fs: 1'b0};
      t = 0; dq = 0; lat_v = 0; lat_d = 0; shw_v = 0; shw_d = 0;
    end else begin
      ph  = (t / 4) % 16;
      ix  = (t / 64) % N;
      nib = 4'((shw_v >> (4 * ix)) & 16'hF);
      bl  = lzs && ix != 0 && (shw_v >> (4 * ix)) == 0 && (shw_d >> ix) == 0;
      e.an = 4'hF;
      if (ph < dq) e.an[ix] = 1'b0;
      e.seg = bl ? 7'h7F : ~glyph[nib];
      e.dp  = ~(shw_d[ix] & !bl);
      t++;
      if (load) begin lat_v = value; lat_d = dp_in; end
      wrp = (t % 256 == 0);
      if (wrp) begin shw_v = lat_v; shw_d = lat_d; end
      if (t % 64 == 0) dq = int'(duty);
      e.fs = wrp;
    end
    q.push_back(e);
  end

  // Monitor: one prediction per clock edge, compared mid-cycle
  always @(negedge clk) begin
    if (q.size() > 0) begin
      m_e = q.pop_front();
      n_cmp++;
      if ({seg, dp, an, frame_sync} !== {m_e.seg, m_e.dp, m_e.an, m_e.fs}) begin
        n_bad++;
        $display("FAIL scan_out @%0t: got seg=%h dp=%b an=%h fs=%b, want seg=%h dp=%b an=%h fs=%b",
                 $time, seg, dp, an, frame_sync, m_e.seg, m_e.dp, m_e.an, m_e.fs);
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] d);
    value = v; dp_in = d; load = 1'b1;
    cyc(1);
    load = 1'b0;
  endtask

  // Advance until the model's frame position equals r (bounded)
  task automatic align(input int r);
    int n;
    n = 0;
    while (t % 256 != r && n < 400) begin cyc(1); n++; end
    n_cmp++;
    if (t % 256 != r) begin
      n_bad++;
      $display("FAIL align: got pos=%0d, want pos=%0d", t % 256, r);
    end
  endtask

  initial begin
    // Reset held with load asserted: must be ignored
    reset_b = 1'b0; load = 1'b1; value = 16'hFFFF; dp_in = 4'hF;
    cyc(5);
    reset_b = 1'b1; load = 1'b0; duty = 4'd8;
    do_load(16'h1234, 4'h0);
    cyc(3 * 256);
    // Duty limits
    duty = 4'd0;  cyc(2 * 256);
    duty = 4'd15; cyc(2 * 256);
    duty = 4'd8;
    // Tear-free mid-frame load, then a load on the wrap edge
    align(100);
    do_load(16'hABCD, 4'h0);
    cyc(300);
    align(255);
    do_load(16'h5A5A, 4'h5);
    cyc(256);
    // Leading-zero suppression
    lzs = 1'b1;
    align(10); do_load(16'h0050, 4'h0); cyc(520);
    align(10); do_load(16'h0000, 4'h0); cyc(520);
    align(10); do_load(16'h0000, 4'h8); cyc(520);
    // Randomised traffic: values, dp, lzs, duty changes mid-slot, double loads
    for (int i = 0; i < 24; i++) begin
      lzs  = 1'($urandom_range(0, 1));
      duty = 4'($urandom_range(0, 15));
      cyc($urandom_range(1, 200));
      do_load(16'($urandom_range(0, 255) << ($urandom_range(0, 2) * 4)), 4'($urandom_range(0, 15) & 4'($urandom_range(0, 15))));
      if ($urandom_range(0, 2) == 0) begin
        cyc($urandom_range(0, 40));
        do_load(16'($urandom), 4'($urandom_range(0, 15)));
      end
      cyc($urandom_range(50, 400));
    end
    // Reset mid-slot: digit 2, phase 5
    duty = 4'd12;
    align(148);
    reset_b = 1'b0;
    cyc(3);
    reset_b = 1'b1;
    cyc(2 * 256 + 17);
    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
